// File: rtl/uart_rx_deframer_if.sv
// Receive-side output bundle of uart_rx_deframer: byte handshake plus status pulses.
// The deframer drives it through the master modport; the dispatcher uses the slave modport.
interface uart_rx_deframer_if;
  logic [7:0] O_DATA;
  logic       O_VALID;
  logic       O_READY;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       BUSY;

  modport master (output O_DATA, O_VALID, FRAME_ERR, OVERRUN, BUSY, input O_READY);
  modport slave  (input  O_DATA, O_VALID, FRAME_ERR, OVERRUN, BUSY, output O_READY);
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer with a one-deep valid/ready output register.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote at counter values 2, 1 and 0.
module uart_rx_deframer #(
  parameter int PRESCALER = 200,
  parameter int CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               UART_RX,
  uart_rx_deframer_if.master rx_if
);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(PRESCALER / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PRESCALER - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t           state, state_d;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shreg;
  logic             samp, bit_v, cap, deliver, ferr, blocked;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= UART_RX;
      rx_s <= rx_m;
    end
  end

  assign samp = (cnt == '0);

`ifdef UART_RX_MAJORITY_EN
  logic s2, s1;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (cnt == CNT_W'(2)) s2 <= rx_s;
      if (cnt == CNT_W'(1)) s1 <= rx_s;
    end
  end
  assign bit_v = (s2 & s1) | (s2 & rx_s) | (s1 & rx_s);
`else
  assign bit_v = rx_s;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    cap     = 1'b0;
    deliver = 1'b0;
    ferr    = 1'b0;
    case (state)
      S_IDLE:
        if (!rx_s) begin
          cnt_d   = HALF;
          state_d = S_START;
        end
      S_START:
        if (!samp) cnt_d = cnt - 1'b1;
        else if (bit_v) state_d = S_IDLE;
        else begin
          cnt_d   = FULL;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      S_DATA:
        if (!samp) cnt_d = cnt - 1'b1;
        else begin
          cap   = 1'b1;
          cnt_d = FULL;
          idx_d = idx + 3'd1;
          if (idx == 3'd7) state_d = S_STOP;
        end
      S_STOP:
        if (!samp) cnt_d = cnt - 1'b1;
        else begin
          deliver = bit_v;
          ferr    = ~bit_v;
          state_d = bit_v ? S_IDLE : S_BRK;
        end
      // Hold off until the line goes idle so a long break is not re-read as start bits.
      S_BRK:
        if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      if (cap) shreg[idx] <= bit_v;
    end
  end

  // A full register that is not being drained this cycle drops the new byte.
  assign blocked = rx_if.O_VALID & ~rx_if.O_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_if.O_DATA    <= 8'h00;
      rx_if.O_VALID   <= 1'b0;
      rx_if.FRAME_ERR <= 1'b0;
      rx_if.OVERRUN   <= 1'b0;
    end else begin
      rx_if.FRAME_ERR <= ferr;
      rx_if.OVERRUN   <= deliver & blocked;
      if (deliver && !blocked) begin
        rx_if.O_DATA  <= shreg;
        rx_if.O_VALID <= 1'b1;
      end else if (rx_if.O_VALID && rx_if.O_READY) begin
        rx_if.O_VALID <= 1'b0;
      end
    end
  end

  assign rx_if.BUSY = (state != S_IDLE);
endmodule
